// File: rtl/rhythm_scoreboard.sv
// -----------------------------------------------------------------------------
// rhythm_scoreboard
//
// Per-round judge that sits downstream of the lane droppers. It edge-detects
// per-lane hit and end-of-drop levels, accumulates a saturating point total,
// tracks the current and best combo, and declares the round finished once
// every lane has resolved.
//
// Optional feature: define RHYTHM_SCOREBOARD_COMBO_BONUS_EN to double the
// points of every hit landed while the pre-update combo is at least
// COMBO_BONUS_MIN. Without the macro every hit scores HIT_POINTS.
//
// Parameters:
//   LANES            number of dropper lanes (1..15)
//   HIT_POINTS       points per hit
//   SCORE_MAX        score saturation value (fits 14 bits)
//   COMBO_BONUS_MIN  minimum pre-update combo for the bonus
//
// Ports:
//   frame_clk     in   1      frame clock, all state updates on rising edge
//   Reset         in   1      asynchronous, active-high reset
//   keycode       in   8      8'h2c starts a round, 8'h01 leaves the result
//   hit           in   LANES  per-lane dropper score level
//   done          in   LANES  per-lane end-of-drop level
//   score         out  14     accumulated points, saturating at SCORE_MAX
//   combo         out  8      current consecutive-hit count, saturating 255
//   max_combo     out  8      best combo this round
//   hit_count     out  4      lanes hit this round
//   miss_count    out  4      lanes missed this round
//   playing       out  1      high in PLAY
//   result_valid  out  1      high in RESULT
// -----------------------------------------------------------------------------
module rhythm_scoreboard #(
   parameter int LANES           = 6,
   parameter int HIT_POINTS      = 100,
   parameter int SCORE_MAX       = 9999,
   parameter int COMBO_BONUS_MIN = 4
) (
   input  logic             frame_clk,
   input  logic             Reset,
   input  logic [7:0]       keycode,
   input  logic [LANES-1:0] hit,
   input  logic [LANES-1:0] done,
   output logic [13:0]      score,
   output logic [7:0]       combo,
   output logic [7:0]       max_combo,
   output logic [3:0]       hit_count,
   output logic [3:0]       miss_count,
   output logic             playing,
   output logic             result_valid
);

   localparam logic [7:0]  KEY_START  = 8'h2c;
   localparam logic [7:0]  KEY_EXIT   = 8'h01;
   localparam logic [13:0] SCORE_CAP  = 14'(SCORE_MAX);
   localparam logic [14:0] POINTS     = 15'(HIT_POINTS);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PLAY   = 2'd1,
      RESULT = 2'd2
   } state_t;

   state_t state;
   state_t state_nx;

   // Edge registers and per-round lane latches.
   logic [LANES-1:0] hit_prev;
   logic [LANES-1:0] done_prev;
   logic [LANES-1:0] hit_lat;
   logic [LANES-1:0] done_lat;

   // Decoded control from the FSM.
   logic start_round;
   logic judge;

   // Judging datapath.
   logic [LANES-1:0] hit_rise;
   logic [LANES-1:0] done_rise;
   logic [LANES-1:0] hit_ev;
   logic [LANES-1:0] miss_ev;
   logic [LANES-1:0] hit_lat_nx;
   logic [LANES-1:0] done_lat_nx;
   logic [3:0]       n_hit;
   logic [3:0]       n_miss;
   logic [14:0]      pts_per_hit;
   logic [14:0]      score_sum;
   logic [13:0]      score_nx;
   logic [8:0]       combo_sum;
   logic [7:0]       combo_nx;
   logic [7:0]       max_combo_nx;
   logic             all_done;

   function automatic logic [3:0] popcount(input logic [LANES-1:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < LANES; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

   // ---------------------------------------------------------------------------
   // Lane judging
   // ---------------------------------------------------------------------------
   assign hit_rise  = hit  & ~hit_prev  & ~hit_lat;
   assign done_rise = done & ~done_prev & ~done_lat;

   // A lane that already resolved as a miss cannot be re-judged as a hit.
   assign hit_ev  = hit_rise & ~done_lat;
   // A done edge only counts as a miss when the note was never hit.
   assign miss_ev = done_rise & ~hit & ~hit_lat;

   assign hit_lat_nx  = hit_lat  | hit_ev;
   assign done_lat_nx = done_lat | done_rise;
   assign all_done    = &done_lat_nx;

   assign n_hit  = popcount(hit_ev);
   assign n_miss = popcount(miss_ev);

   // ---------------------------------------------------------------------------
   // Score and combo arithmetic
   // ---------------------------------------------------------------------------
`ifdef RHYTHM_SCOREBOARD_COMBO_BONUS_EN
   localparam logic [8:0] BONUS_MIN = 9'(COMBO_BONUS_MIN);
   // The bonus is decided on the combo held before this cycle's update.
   assign pts_per_hit = ({1'b0, combo} >= BONUS_MIN) ? (POINTS << 1) : POINTS;
`else
   assign pts_per_hit = POINTS;
`endif

   // 15-bit sum leaves headroom above SCORE_MAX before the clamp.
   assign score_sum = {1'b0, score} + pts_per_hit * {11'b0, n_hit};
   assign score_nx  = (score_sum > {1'b0, SCORE_CAP}) ? SCORE_CAP : score_sum[13:0];

   assign combo_sum = {1'b0, combo} + {5'b0, n_hit};

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      combo_nx = combo_sum[8] ? 8'hff : combo_sum[7:0];
      if (n_miss != 4'd0) begin
         // Any miss in the cycle breaks the chain, even alongside hits.
         combo_nx = 8'd0;
      end
      max_combo_nx = (combo_nx > max_combo) ? combo_nx : max_combo;
   end

   // ---------------------------------------------------------------------------
   // FSM: next state and decoded outputs from the registered state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nx     = state;
      start_round  = 1'b0;
      judge        = 1'b0;
      playing      = 1'b0;
      result_valid = 1'b0;
      unique case (state)
         IDLE: begin
            if (keycode == KEY_START) begin
               state_nx    = PLAY;
               start_round = 1'b1;
            end
         end
         PLAY: begin
            playing = 1'b1;
            judge   = 1'b1;
            if (all_done) begin
               state_nx = RESULT;
            end
         end
         RESULT: begin
            result_valid = 1'b1;
            if (keycode == KEY_EXIT) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State register and counters
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         hit_prev   <= '0;
         done_prev  <= '0;
         hit_lat    <= '0;
         done_lat   <= '0;
         score      <= '0;
         combo      <= '0;
         max_combo  <= '0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         state <= state_nx;

         // Loading the live inputs every edge, including the start edge,
         // means a level already high when the round opens never counts.
         hit_prev  <= hit;
         done_prev <= done;

         if (start_round) begin
            hit_lat    <= '0;
            done_lat   <= '0;
            score      <= '0;
            combo      <= '0;
            max_combo  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
         end else if (judge) begin
            hit_lat    <= hit_lat_nx;
            done_lat   <= done_lat_nx;
            score      <= score_nx;
            combo      <= combo_nx;
            max_combo  <= max_combo_nx;
            // Each lane resolves at most once, so these cannot exceed LANES.
            hit_count  <= hit_count + n_hit;
            miss_count <= miss_count + n_miss;
         end
      end
   end

endmodule
